// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, default widths and the FSM state type.
package muldiv_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_CNT_W = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the exec stage (master) and the mul/div unit (slave).
// Both channels are valid/ready: a transfer happens on a rising clk edge where valid and ready are both high; valid must hold until then.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic [4:0]      req_rd;
    logic            kill;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic [4:0]      resp_rd;
    logic            busy;

    modport master (
        output req_valid, req_funct3, req_a, req_b, req_rd, kill, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_rd, busy
    );

    modport slave (
        input  req_valid, req_funct3, req_a, req_b, req_rd, kill, resp_ready,
        output req_ready, resp_valid, resp_result, resp_rd, busy
    );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Operand conditioning: turns a/b into magnitudes according to the signedness
// implied by funct3 and reports whether the selected result must be negated.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] a_mag,
    output logic [XLEN-1:0] b_mag,
    output logic            res_neg
);
    logic a_signed;
    logic b_signed;
    logic a_neg;
    logic b_neg;

    always_comb begin
        a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV) || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                   (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_neg    = a_signed & a[XLEN-1];
        b_neg    = b_signed & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        // A remainder follows the dividend's sign; everything else is sign(a)^sign(b).
        res_neg  = (funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, one request
// in flight, divide-by-zero and signed overflow answered without iterating.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic   clk,
    input  logic   reset_n,
    muldiv_if.slave bus,
    output state_t dbg_state
);
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [2:0]          f3_q, f3_d;
    logic [4:0]          rd_q, rd_d;
    logic                neg_q, neg_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                busy_q, busy_d;
    logic [XLEN-1:0]     resp_result_q, resp_result_d;
    logic [4:0]          resp_rd_q, resp_rd_d;

    logic [XLEN-1:0]     a_mag, b_mag;
    logic                in_neg;
    logic                div_by_zero, div_ovf;
    logic [XLEN-1:0]     special_res;
    logic [XLEN:0]       mul_sum, rem_sh, rem_diff;
    logic [2*XLEN-1:0]   acc_step, prod_fix;
    logic [XLEN-1:0]     div_word, div_fix, final_res;

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .funct3  (bus.req_funct3),
        .a       (bus.req_a),
        .b       (bus.req_b),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .res_neg (in_neg)
    );

    always_comb begin
        div_by_zero = bus.req_funct3[2] && (bus.req_b == '0);
        div_ovf     = bus.req_funct3[2] && !bus.req_funct3[0] &&
                      (bus.req_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.req_b == '1);
        if (div_by_zero)
            special_res = bus.req_funct3[1] ? bus.req_a : '1;
        else
            special_res = bus.req_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // Step datapath: low half of acc holds the multiplier (shifted out) or the
    // dividend (shifted into the remainder), high half accumulates.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_diff = rem_sh - {1'b0, opb_q};
        if (!f3_q[2])
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        else if (!rem_diff[XLEN])
            acc_step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        // The product is negated as a whole so MULH* see the correct borrow.
        prod_fix = neg_q ? -acc_step : acc_step;
        div_word = f3_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
        div_fix  = neg_q ? -div_word : div_word;
        if (!f3_q[2])
            final_res = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else
            final_res = div_fix;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        opb_d         = opb_q;
        f3_d          = f3_q;
        rd_d          = rd_q;
        neg_d         = neg_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        busy_d        = busy_q;
        resp_result_d = resp_result_q;
        resp_rd_d     = resp_rd_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && !bus.kill) begin
                    f3_d        = bus.req_funct3;
                    rd_d        = bus.req_rd;
                    neg_d       = in_neg;
                    cnt_d       = '0;
                    acc_d       = {{XLEN{1'b0}}, a_mag};
                    opb_d       = b_mag;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (div_by_zero || div_ovf) begin
                        state_d       = S_DONE;
                        resp_valid_d  = 1'b1;
                        resp_result_d = special_res;
                        resp_rd_d     = bus.req_rd;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.kill) begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d       = S_DONE;
                        resp_valid_d  = 1'b1;
                        resp_result_d = final_res;
                        resp_rd_d     = rd_q;
                        cnt_d         = '0;
                    end
                end
            end
            S_DONE: begin
                if (bus.kill || bus.resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            opb_q         <= '0;
            f3_q          <= '0;
            rd_q          <= '0;
            neg_q         <= 1'b0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            resp_result_q <= '0;
            resp_rd_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            opb_q         <= opb_d;
            f3_q          <= f3_d;
            rd_q          <= rd_d;
            neg_q         <= neg_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            busy_q        <= busy_d;
            resp_result_q <= resp_result_d;
            resp_rd_q     <= resp_rd_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_rd     = resp_rd_q;
    assign bus.busy        = busy_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a driver pushes {first-valid cycle, rd, result}
// into exp_q and an independent monitor checks each response handshake.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int EW = 16 + 5 + 32;

    logic   clk;
    logic   reset_n;
    state_t dbg_state;
    int     cyc = 0;
    int     total = 0;
    int     bad = 0;
    logic [EW-1:0] exp_q[$];

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int start_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f3;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_rd     = rd;
        start_cyc      = cyc;
        @(negedge clk);
        bus.req_valid  = 1'b0;
    endtask

    // lat counts the cycle right after the accept edge as cycle 1.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input int lat);
        int sc;
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
        exp_q.push_back({16'(cyc + lat), rd, exp_res});
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f3;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_rd     = rd;
        sc             = cyc;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        if (cyc != sc + 1) check("accept_timing", 32'(cyc), 32'(sc + 1));
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check(name, 32'(bus.resp_valid), 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"},   32'(bus.req_ready),  32'd1);
        check({tag, "_resp_valid"},  32'(bus.resp_valid), 32'd0);
        check({tag, "_busy"},        32'(bus.busy),       32'd0);
        check({tag, "_state"},       32'(dbg_state),      32'(S_IDLE));
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0] e;
        bit seen;
        int first_cyc;
        seen = 0;
        first_cyc = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n || !bus.resp_valid) begin
                seen = 0;
            end else begin
                if (!seen) begin
                    seen = 1;
                    first_cyc = cyc;
                end
                if (bus.resp_ready && !bus.kill) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_resp: got result %h rd %0d, expected no response",
                                 bus.resp_result, bus.resp_rd);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_result", bus.resp_result, e[31:0]);
                        check("resp_rd", 32'(bus.resp_rd), 32'(e[36:32]));
                        check("latency_cycle", 32'(first_cyc), 32'(e[52:37]));
                    end
                    seen = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int sc;
        bit saw_valid;
        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_rd     = '0;
        bus.kill       = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_result", bus.resp_result, 32'd0);
        check("reset_rd", 32'(bus.resp_rd), 32'd0);
        reset_n = 1'b1;

        // Multiply family
        issue(F3_MUL,    32'd5,          32'd3,          5'd3, 32'd15,         33);
        issue(F3_MULH,   32'h8000_0000,  32'h8000_0000,  5'd4, 32'h4000_0000,  33);
        issue(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5, 32'hFFFF_FFFE,  33);
        issue(F3_MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd6, 32'hFFFF_FFFF,  33);
        issue(F3_MUL,    32'hFFFF_FFFD,  32'd7,          5'd8, 32'hFFFF_FFEB,  33);

        // Divide family
        issue(F3_DIV,    32'hFFFF_FFF9,  32'd2,          5'd10, 32'hFFFF_FFFD, 33);
        issue(F3_REM,    32'hFFFF_FFF9,  32'd2,          5'd11, 32'hFFFF_FFFF, 33);
        issue(F3_DIVU,   32'd100,        32'd7,          5'd12, 32'd14,        33);
        issue(F3_REMU,   32'd100,        32'd7,          5'd13, 32'd2,         33);

        // Fast-path special cases
        issue(F3_DIV,    32'd42,         32'd0,          5'd14, 32'hFFFF_FFFF, 1);
        issue(F3_REMU,   32'd42,         32'd0,          5'd15, 32'd42,        1);
        issue(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h8000_0000, 1);
        issue(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'd0,         1);
        wait_drain();

        // Backpressure: result held while resp_ready is low
        bus.resp_ready = 1'b0;
        issue(F3_MUL, 32'd9, 32'd9, 5'd7, 32'd81, 33);
        wait_valid("bp_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            check("bp_valid",     32'(bus.resp_valid), 32'd1);
            check("bp_result",    bus.resp_result,     32'd81);
            check("bp_rd",        32'(bus.resp_rd),    32'd7);
            check("bp_req_ready", 32'(bus.req_ready),  32'd0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check_idle_outputs("bp_release");
        wait_drain();

        // kill in IDLE: request must not be taken
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_funct3 = F3_MUL;
        bus.req_a      = 32'd1;
        bus.req_b      = 32'd1;
        bus.kill       = 1'b1;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.kill       = 1'b0;
        check_idle_outputs("kill_idle");

        // kill at CALC counter=10
        start(F3_MUL, 32'd1234, 32'd5678, 5'd20, sc);
        repeat (10) @(negedge clk);
        check("kill_calc_state", 32'(dbg_state), 32'(S_CALC));
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check_idle_outputs("kill_calc");
        saw_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.resp_valid) saw_valid = 1;
        end
        check("kill_no_resp", 32'(saw_valid), 32'd0);
        issue(F3_MUL, 32'd6, 32'd7, 5'd9, 32'd42, 33);
        wait_drain();

        // kill in DONE discards the held result
        bus.resp_ready = 1'b0;
        start(F3_MUL, 32'd2, 32'd2, 5'd21, sc);
        wait_valid("kill_done_valid_timeout");
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        bus.resp_ready = 1'b1;
        check_idle_outputs("kill_done");

        // Asynchronous reset in the middle of CALC
        start(F3_MUL, 32'd3, 32'd3, 5'd22, sc);
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        check("async_reset_result", bus.resp_result, 32'd0);
        check("async_reset_rd", 32'(bus.resp_rd), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Recovery after reset
        issue(F3_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd31, 32'h0FFF_FFFF, 33);
        wait_drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
